// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared async FIFO constants and Gray/binary pointer helpers
package async_fifo_pkg;

  localparam int ADDRSIZE_DEFAULT = 6;

  // Operands are zero-extended pointers, so upper result bits stay zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for Gray pointers crossing clock domains
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

// File: rtl/write_handler.sv
// rtl/write_handler.sv - async FIFO write-side pointer, full, level and overflow logic
// Optional almost-full output under macro WR_ALMOST_FULL_EN.
module write_handler
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE  = ADDRSIZE_DEFAULT,
  parameter int AF_THRESH = 2**ADDRSIZE - 4
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic              wr_ovf_clr,
  input  logic [ADDRSIZE:0] wr_rptr_gray,
  output logic [ADDRSIZE:0] wr_addr,
  output logic [ADDRSIZE:0] wr_ptr,
  output logic              wr_mem_en,
  output logic              wr_full,
  output logic [ADDRSIZE:0] wr_level,
  output logic              wr_overflow
`ifdef WR_ALMOST_FULL_EN
  , output logic            wr_almost_full
`endif
);

  logic [ADDRSIZE:0] r_addr;
  logic [ADDRSIZE:0] r_ptr;
  logic              r_full;
  logic [ADDRSIZE:0] r_level;
  logic              r_overflow;

  logic [ADDRSIZE:0] w_wq2;
  logic              w_mem_en;
  logic [ADDRSIZE:0] w_bin_next;
  logic [31:0]       w_gray32;
  logic [ADDRSIZE:0] w_gray_next;
  logic [31:0]       w_rbin32;
  logic [ADDRSIZE:0] w_rbin;
  logic [ADDRSIZE:0] w_level_next;
  logic [ADDRSIZE:0] w_full_pattern;
  logic              w_full_next;
  logic              w_unused;

  sync_2ff #(
    .WIDTH (ADDRSIZE+1)
  ) u_rptr_sync (
    .i_clk (wr_clk),
    .i_rst (wr_rst),
    .i_d   (wr_rptr_gray),
    .o_q   (w_wq2)
  );

  assign w_mem_en    = wr_en & ~r_full;
  assign w_bin_next  = r_addr + {{ADDRSIZE{1'b0}}, w_mem_en};
  assign w_gray32    = bin2gray(32'(w_bin_next));
  assign w_gray_next = w_gray32[ADDRSIZE:0];
  assign w_rbin32    = gray2bin(32'(w_wq2));
  assign w_rbin      = w_rbin32[ADDRSIZE:0];
  assign w_level_next = w_bin_next - w_rbin;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign w_full_pattern = {~w_wq2[ADDRSIZE:ADDRSIZE-1], w_wq2[ADDRSIZE-2:0]};
  assign w_full_next    = (w_gray_next == w_full_pattern);

  assign w_unused = ^{w_gray32[31:ADDRSIZE+1], w_rbin32[31:ADDRSIZE+1], AF_THRESH[0]};

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_addr     <= '0;
      r_ptr      <= '0;
      r_full     <= 1'b0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_addr  <= w_bin_next;
      r_ptr   <= w_gray_next;
      r_full  <= w_full_next;
      r_level <= w_level_next;
      // A rejected write outranks a clear arriving in the same cycle.
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (wr_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef WR_ALMOST_FULL_EN
  logic r_almost_full;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= (ADDRSIZE+1)'(AF_THRESH));
    end
  end

  assign wr_almost_full = r_almost_full;
`endif

  assign wr_addr     = r_addr;
  assign wr_ptr      = r_ptr;
  assign wr_mem_en   = w_mem_en;
  assign wr_full     = r_full;
  assign wr_level    = r_level;
  assign wr_overflow = r_overflow;

endmodule

// File: tb/tb_write_handler.sv
// tb/tb_write_handler.sv - directed self-checking bench for write_handler at depth 4
module tb_write_handler;

  localparam int ADDRSIZE  = 2;
  localparam int AF_THRESH = 3;

  logic                wr_clk = 1'b0;
  logic                wr_rst = 1'b1;
  logic                wr_en = 1'b0;
  logic                wr_ovf_clr = 1'b0;
  logic [ADDRSIZE:0]   wr_rptr_gray = '0;
  logic [ADDRSIZE:0]   wr_addr;
  logic [ADDRSIZE:0]   wr_ptr;
  logic                wr_mem_en;
  logic                wr_full;
  logic [ADDRSIZE:0]   wr_level;
  logic                wr_overflow;
`ifdef WR_ALMOST_FULL_EN
  logic                wr_almost_full;
`endif

  int checks = 0;
  int errors = 0;

  always #5 wr_clk = ~wr_clk;

  write_handler #(
    .ADDRSIZE  (ADDRSIZE),
    .AF_THRESH (AF_THRESH)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .wr_en        (wr_en),
    .wr_ovf_clr   (wr_ovf_clr),
    .wr_rptr_gray (wr_rptr_gray),
    .wr_addr      (wr_addr),
    .wr_ptr       (wr_ptr),
    .wr_mem_en    (wr_mem_en),
    .wr_full      (wr_full),
    .wr_level     (wr_level),
    .wr_overflow  (wr_overflow)
`ifdef WR_ALMOST_FULL_EN
    , .wr_almost_full (wr_almost_full)
`endif
  );

  function automatic logic [2:0] gray3(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int count;
    logic [2:0] rp;

    tick();
    tick();
    check("rst_addr",  32'(wr_addr), 32'd0);
    check("rst_ptr",   32'(wr_ptr), 32'd0);
    check("rst_full",  32'(wr_full), 32'd0);
    check("rst_level", 32'(wr_level), 32'd0);
    check("rst_ovf",   32'(wr_overflow), 32'd0);
`ifdef WR_ALMOST_FULL_EN
    check("rst_af",    32'(wr_almost_full), 32'd0);
`endif

    wr_rst = 1'b0;
    wr_rptr_gray = 3'b000;
    wr_en = 1'b1;
    #1;
    check("fill_mem_en", 32'(wr_mem_en), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("fill_addr",  32'(wr_addr), 32'(i));
      check("fill_level", 32'(wr_level), 32'(i));
      check("fill_full",  32'(wr_full), (i == 4) ? 32'd1 : 32'd0);
`ifdef WR_ALMOST_FULL_EN
      check("fill_af",    32'(wr_almost_full), (i >= 3) ? 32'd1 : 32'd0);
`endif
    end
    check("fill_ptr", 32'(wr_ptr), 32'b110);

    check("ovf_mem_en", 32'(wr_mem_en), 32'd0);
    tick();
    check("ovf_addr", 32'(wr_addr), 32'b100);
    check("ovf_set",  32'(wr_overflow), 32'd1);
    wr_en = 1'b0;
    wr_ovf_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(wr_overflow), 32'd0);
    wr_en = 1'b1;
    tick();
    check("ovf_set_wins", 32'(wr_overflow), 32'd1);
    wr_en = 1'b0;
    tick();
    check("ovf_clr2", 32'(wr_overflow), 32'd0);
    wr_ovf_clr = 1'b0;

    wr_rptr_gray = 3'b001;
    tick();
    check("rsync_e1_full", 32'(wr_full), 32'd1);
    tick();
    check("rsync_e2_full",  32'(wr_full), 32'd1);
    check("rsync_e2_level", 32'(wr_level), 32'd4);
    tick();
    check("rsync_e3_full",  32'(wr_full), 32'd0);
    check("rsync_e3_level", 32'(wr_level), 32'd3);

    wr_en = 1'b1;
    tick();
    check("refill_addr", 32'(wr_addr), 32'b101);
    check("refill_full", 32'(wr_full), 32'd1);
    wr_rst = 1'b1;
    wr_rptr_gray = 3'b000;
    tick();
    check("mrst_addr",  32'(wr_addr), 32'd0);
    check("mrst_ptr",   32'(wr_ptr), 32'd0);
    check("mrst_full",  32'(wr_full), 32'd0);
    check("mrst_level", 32'(wr_level), 32'd0);
    check("mrst_ovf",   32'(wr_overflow), 32'd0);
    wr_en = 1'b0;
    wr_rst = 1'b0;
    tick();

    count = 0;
    for (int i = 0; i < 10; i++) begin
      rp = (count == 0) ? 3'd0 : 3'(count - 1);
      wr_rptr_gray = gray3(rp);
      wr_en = 1'b0;
      tick();
      tick();
      tick();
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      count++;
      check("wrap_addr",  32'(wr_addr), 32'(count % 8));
      check("wrap_full",  32'(wr_full), 32'd0);
      check("wrap_level", 32'(wr_level), (count == 1) ? 32'd1 : 32'd2);
    end
    check("wrap_ptr", 32'(wr_ptr), 32'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_handler.md
WRITE_HANDLER -- requirements
Module: write_handler

Interface
REQ-001 Parameter ADDRSIZE, default 6, FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
REQ-002 Parameter AF_THRESH, default 2**ADDRSIZE-4, almost-full level threshold (used only under WR_ALMOST_FULL_EN).
REQ-003 wr_clk  in  1  write-domain clock; single clock for the block.
REQ-004 wr_rst  in  1  reset, synchronous to wr_clk, active-high.
REQ-005 wr_en  in  1  write request from producer.
REQ-006 wr_ovf_clr  in  1  clears sticky overflow flag.
REQ-007 wr_rptr_gray  in  ADDRSIZE+1  Gray read pointer from read domain (asynchronous to wr_clk).
REQ-008 wr_addr  out  ADDRSIZE+1  registered binary write pointer; memory uses bits [ADDRSIZE-1:0].
REQ-009 wr_ptr  out  ADDRSIZE+1  registered Gray write pointer, sent to read domain.
REQ-010 wr_mem_en  out  1  combinational memory write strobe = wr_en & !wr_full.
REQ-011 wr_full  out  1  registered full flag.
REQ-012 wr_level  out  ADDRSIZE+1  registered fill level as seen from write domain (0..2**ADDRSIZE).
REQ-013 wr_overflow  out  1  sticky flag: write attempted while full.
REQ-014 wr_almost_full  out  1  registered almost-full flag (present only under WR_ALMOST_FULL_EN).

Function
REQ-015 wr_rptr_gray SHALL pass through a 2-flop synchronizer (wq1, wq2) before any use; no other logic reads it.
REQ-016 Next binary pointer wbin_next = wr_addr + wr_mem_en, modulo 2**(ADDRSIZE+1); next Gray = (wbin_next>>1) ^ wbin_next.
REQ-017 Each rising wr_clk edge: wr_addr <= wbin_next, wr_ptr <= Gray(wbin_next); pointer wraps from all-ones to 0 with no special case.
REQ-018 wr_full <= (Gray(wbin_next) == {~wq2[ADDRSIZE:ADDRSIZE-1], wq2[ADDRSIZE-2:0]}); ADDRSIZE>=2 required.
REQ-019 wr_level <= wbin_next - gray2bin(wq2), modulo 2**(ADDRSIZE+1).
REQ-020 wr_en while wr_full=1: no pointer change, no memory strobe, wr_overflow <= 1.
REQ-021 wr_overflow cleared by wr_ovf_clr; simultaneous overflow event and wr_ovf_clr -> wr_overflow=1 (set wins).
REQ-022 Read-pointer change propagation: wr_full/wr_level reflect a new wr_rptr_gray on the 3rd rising edge after it becomes stable.
REQ-023 wr_full is pessimistic: it may stay asserted up to 3 cycles after space frees; it SHALL never be low while the FIFO is full.
REQ-024 Write accepted on the cycle that makes the FIFO full: wr_full=1 on the following edge, never later.

Reset
REQ-025 wr_rst=1 at a rising edge: wr_addr=0, wr_ptr=0, wq1=wq2=0, wr_full=0, wr_level=0, wr_overflow=0, wr_almost_full=0; reset overrides wr_en and wr_ovf_clr.
REQ-026 Reset mid-operation discards in-flight state; read domain SHALL be reset in the same window (system rule, not checked here).

Configuration
REQ-027 Macro WR_ALMOST_FULL_EN defined: wr_almost_full port exists, wr_almost_full <= (wbin_next - gray2bin(wq2)) >= AF_THRESH.
REQ-028 Macro WR_ALMOST_FULL_EN undefined: port and its logic absent; all other behaviour identical.

Structure
REQ-029 Shared package async_fifo_pkg SHALL hold bin2gray/gray2bin functions and default ADDRSIZE constant, also used by read-side logic.
REQ-030 Synchronizer SHALL be sub-module sync_2ff (parameter WIDTH, synchronous active-high reset), reusable by the read side.

Verification (ADDRSIZE=2, depth 4, AF_THRESH=3)
REQ-031 Reset, then wr_rptr_gray=0, 4 consecutive wr_en -> wr_addr 1,2,3,4 (3'b100), wr_ptr 3'b110, wr_full=1 after 4th edge, wr_level=4.
REQ-032 Full, 5th wr_en -> wr_mem_en=0, wr_addr stays 3'b100, wr_overflow=1; wr_ovf_clr pulse -> 0; overflow+clr same cycle -> 1.
REQ-033 Full, wr_rptr_gray 3'b000->3'b001 -> wr_full=0 and wr_level=3 on 3rd edge, not earlier.
REQ-034 Drive 10 writes with read pointer following (Gray of count-2) -> wr_addr wraps 3'b111->3'b000, wr_full never asserts, wr_level stays <=2.
REQ-035 WR_ALMOST_FULL_EN defined, rptr=0: writes 1..3 -> wr_almost_full rises with 3rd accepted write; undefined build compiles without the port.
REQ-036 wr_rst asserted with wr_en=1 while full -> all outputs zero next edge, no overflow set.
